// File: rtl/counter_pkg.sv
// Shared types and the reference next-count rule for the step counter.
// The saturating variant is selected in the top by COUNTER_SATURATE_EN.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 4;
  localparam int COUNTER_WIDTH_MIN     = 2;
  localparam int COUNTER_WIDTH_MAX     = 32;

  typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

  // Wrapped (sat=0) or clamped-to-all-ones (sat=1) sum at the default width.
  function automatic count_t next_count(input count_t cur, input count_t step, input logic sat);
    logic [COUNTER_WIDTH_DEFAULT:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sat && sum[COUNTER_WIDTH_DEFAULT]) begin
      return '1;
    end
    return sum[COUNTER_WIDTH_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/counter.sv
// Synchronous step counter: adds count_in to the count on each enabled edge.
// Define COUNTER_SATURATE_EN to clamp at all ones instead of wrapping.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count_out
);

`ifdef COUNTER_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   sum_d;

  // The extra top bit of sum_d is the carry that decides wrap versus clamp.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    sum_d   = {1'b0, count_q} + {1'b0, count_in};
    count_d = sum_d[WIDTH-1:0];
    if (SatEn && sum_d[WIDTH]) begin
      count_d = '1;
    end
  end

  // An X or Z on enable is not 1, so the count holds.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else if (enable == 1'b1) begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (WIDTH >= COUNTER_WIDTH_MIN && WIDTH <= COUNTER_WIDTH_MAX)
      else $error("counter: WIDTH %0d outside legal range", WIDTH);
    if (reset !== 1'b1) begin
      assert (!$isunknown(enable))
        else $warning("counter: enable is X/Z while out of reset");
      if (enable === 1'b1) begin
        assert (!$isunknown(count_in))
          else $warning("counter: count_in is X/Z on an enabled edge");
      end
    end
  end

  // At the default width the datapath must agree with the package helper.
  if (WIDTH == COUNTER_WIDTH_DEFAULT) begin : g_ref_check
    always @(posedge clk) begin
      if (reset === 1'b0 && enable === 1'b1 && !$isunknown(count_in)) begin
        assert (count_d == next_count(count_q, count_in, SatEn))
          else $error("counter: datapath disagrees with next_count");
      end
    end
  end
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_counter;

  localparam int  W   = 4;
  localparam int  MAX = (1 << W) - 1;
`ifdef COUNTER_SATURATE_EN
  localparam bit  SAT = 1'b1;
`else
  localparam bit  SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] count_in;
  logic [W-1:0] count_out;

  int errors = 0;
  int checks = 0;

  int model       = 0;
  bit model_valid = 1'b0;

  counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .count_in (count_in),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: the spec's arithmetic on plain integers.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model       = 0;
      model_valid = 1'b1;
    end else if (model_valid && enable === 1'b1) begin
      if (SAT) model = (model + int'(count_in) > MAX) ? MAX : model + int'(count_in);
      else     model = (model + int'(count_in)) % (MAX + 1);
    end
  end

  always @(negedge clk) begin
    if (model_valid) check("model_track", int'(count_out), model);
  end

  task automatic cycle(input logic r, input logic e, input logic [W-1:0] ci);
    reset    = r;
    enable   = e;
    count_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_after(input string name, input logic e, input logic [W-1:0] ci,
                              input int exp);
    cycle(1'b0, e, ci);
    check(name, int'(count_out), exp);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; count_in = '0;

    // Reset with enable unknown, then hold through an unknown enable.
    cycle(1'b1, 1'bx, 4'd1);
    check("reset_clears", int'(count_out), 0);
    expect_after("hold_after_reset", 1'bx, 4'd0, 0);

    // Unit count from 0.
    for (int i = 1; i <= 5; i++) expect_after("unit_count", 1'b1, 4'd1, i);

    // Wrap / saturate: 15+1, 14+3, 15+15.
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("preload_15", 1'b1, 4'd15, 15);
    expect_after("wrap_15p1", 1'b1, 4'd1, SAT ? 15 : 0);
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("preload_14", 1'b1, 4'd14, 14);
    expect_after("wrap_14p3", 1'b1, 4'd3, SAT ? 15 : 1);
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("preload_15b", 1'b1, 4'd15, 15);
    expect_after("wrap_15p15", 1'b1, 4'd15, SAT ? 15 : 14);

    // Hold with enable low, then step 0 with enable high.
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("preload_7", 1'b1, 4'd7, 7);
    for (int i = 0; i < 3; i++) expect_after("hold_en0", 1'b0, 4'd5, 7);
    expect_after("hold_step0", 1'b1, 4'd0, 7);

    // Reset priority, and no asynchronous effect before the edge.
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("preload_9", 1'b1, 4'd9, 9);
    reset = 1'b1; enable = 1'b1; count_in = 4'd2;
    #1;
    check("reset_is_sync", int'(count_out), 9);
    @(posedge clk);
    #1;
    check("reset_priority", int'(count_out), 0);
    expect_after("resume_after_reset", 1'b1, 4'd2, 2);

    // Step change mid-run.
    cycle(1'b1, 1'b0, 4'd0);
    expect_after("step_change_1", 1'b1, 4'd1, 1);
    expect_after("step_change_2", 1'b1, 4'd1, 2);
    expect_after("step_change_6", 1'b1, 4'd4, 6);
    expect_after("step_change_8", 1'b1, 4'd2, 8);

    // Randomized run, tracked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
            W'($urandom_range(MAX)));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
